tt_response_checker: RTL and testbench
======================================

# tt_response_checker

Sequential response checker for the 4-input truth-table labs: the receiving end of the exhaustive A/B/C/D stimulus sweep. Each time a new input vector is applied to the combinational block under test, the checker latches it and waits a programmable settle time. It then samples the block's output F and compares it against an expected 16-entry truth table. It tracks minterm coverage, counts mismatches and flags pass/fail once all 16 minterms have been checked. It sits beside the combinational block in the lab bench and replaces manual waveform inspection of the sweep.

## Interface
- EXPECT, 16'hA5F0, expected truth table; bit i is the expected F for minterm i = {A,B,C,D} (A is the MSB)
- SETTLE, 2, cycles between vector capture and F sampling; legal range 1..15

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  begin/restart a check run (single-cycle pulse)
- in_valid  in  1  pulse: a new vector is present on A..D this cycle
- A, B, C, D  in  1 each  vector under test, A = MSB of the minterm index
- F  in  1  output of the block under test
- busy  out  1  run in progress (states RUN, SETTLE, CHECK)
- mismatch  out  1  one-cycle pulse on a failed compare
- err_count  out  5  mismatch count, saturating at 31
- covered  out  16  bit i set once minterm i has been checked
- fail_seen  out  1  at least one mismatch in this run
- fail_index  out  4  minterm index of the first mismatch
- done  out  1  all 16 minterms checked; held until start or rst
- pass  out  1  done && err_count == 0

## Operation
- States: IDLE, RUN, SETTLE, CHECK, DONE.
- IDLE: in_valid is ignored. start clears err_count, covered, fail_seen and fail_index, then moves to RUN.
- RUN: in_valid latches {A,B,C,D} into vec, loads the settle counter with SETTLE and moves to SETTLE.
- SETTLE: the counter decrements once per cycle and the state moves to CHECK when it reaches 1. If in_valid is asserted again, the checker re-latches vec, reloads the counter and abandons the earlier vector unchecked.
- CHECK: F is compared with EXPECT[vec], and covered[vec] is set.
  - On mismatch: pulse mismatch and increment err_count (saturating at 31).
  - On the first mismatch of a run: set fail_seen and set fail_index to vec.
  - Next state is DONE if covered becomes 16'hFFFF, otherwise RUN.
- Repeat vectors are checked again: errors count, and coverage does not change.
- DONE: done=1, and pass = (err_count == 0). in_valid is ignored. start behaves as it does in IDLE.
- start in RUN, SETTLE or CHECK aborts the run, clears all results and moves to RUN. start has priority over in_valid in the same cycle.
- The only arithmetic is err_count, a 5-bit saturating increment. It never wraps from 31 to 0.

## Timing
- Reset values:
  - state = IDLE
  - busy, mismatch, fail_seen, done and pass = 0
  - err_count = 0, covered = 16'h0000, fail_index = 0
- rst is asynchronous: asserting it mid-run clears every output immediately, without waiting for a clock edge.
- Latency: in_valid sampled at edge k → F sampled at edge k+SETTLE+1. mismatch, err_count and covered update at that same edge.
- done rises at the same edge as the final covered bit.
- mismatch is high for exactly one cycle per failed compare.
- Minimum vector spacing without abandonment: SETTLE+2 cycles. in_valid that lands in CHECK is ignored.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset check: assert rst for 3 cycles, release → busy=0, done=0, err_count=0, covered=0000, fail_index=0.
- Clean sweep: start, then minterms 0..15 in order at 20-cycle spacing with F=EXPECT[i] → 16 compares, no mismatch pulses, done=1 after the 16th, pass=1, covered=FFFF.
- Faulty sweep: same as the clean sweep but F inverted on minterms 5 and 9 → two mismatch pulses, err_count=2, fail_seen=1, fail_index=5, done=1, pass=0.
- Retrigger during settle: with SETTLE=4, in_valid for vector 3 and then vector 7 two cycles later → only minterm 7 is compared, covered=0080, vector 3 remains uncovered.
- Repeats and saturation:
  - Drive 40 wrong-F vectors over minterms 0..14 only → err_count=31 (saturated), covered=7FFF, done=0.
  - Then drive minterm 15 correctly → done=1, pass=0.
- Mid-run reset and restart:
  - Assert rst during SETTLE of the 8th vector → all outputs clear immediately and the checker is in IDLE.
  - in_valid pulses before start are ignored.
  - After start, a full clean sweep → pass=1.

Source files
------------

// File: rtl/tt_response_checker.sv
// tt_response_checker: receiving end of the 4-input truth-table sweep.
// Each applied vector is latched and allowed to settle for SETTLE cycles.
// F is then compared against the expected truth table. Coverage, the error
// count and the first failing minterm are tracked, and pass/fail is flagged
// once all 16 minterms have been checked.
module tt_response_checker #(
  parameter logic [15:0] EXPECT = 16'hA5F0,
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic        A,
  input  logic        B,
  input  logic        C,
  input  logic        D,
  input  logic        F,
  output logic        busy,
  output logic        mismatch,
  output logic [4:0]  err_count,
  output logic [15:0] covered,
  output logic        fail_seen,
  output logic [3:0]  fail_index,
  output logic        done,
  output logic        pass
);

  localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE);
  localparam logic [4:0]  ERR_MAX     = 5'd31;
  localparam logic [15:0] ALL_COVERED = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  vec;
  logic [3:0]  vec_next;
  logic [3:0]  cnt;
  logic [3:0]  cnt_next;
  logic [4:0]  err_next;
  logic [15:0] covered_next;
  logic        fail_seen_next;
  logic [3:0]  fail_index_next;
  logic        mismatch_next;
  logic        busy_next;
  logic        done_next;
  logic        pass_next;

  // State register; rst returns the checker to IDLE without waiting for a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and next-result logic; start overrides everything, including in_valid.
  always_comb begin
    state_next      = state;
    vec_next        = vec;
    cnt_next        = cnt;
    err_next        = err_count;
    covered_next    = covered;
    fail_seen_next  = fail_seen;
    fail_index_next = fail_index;
    mismatch_next   = 1'b0;

    if (start) begin
      state_next      = S_RUN;
      err_next        = '0;
      covered_next    = '0;
      fail_seen_next  = 1'b0;
      fail_index_next = '0;
    end else begin
      case (state)
        S_RUN: begin
          if (in_valid) begin
            vec_next   = {A, B, C, D};
            cnt_next   = SETTLE_LOAD;
            state_next = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (in_valid) begin
            vec_next = {A, B, C, D};
            cnt_next = SETTLE_LOAD;
          end else if (cnt <= 4'd1) begin
            state_next = S_CHECK;
          end else begin
            cnt_next = cnt - 4'd1;
          end
        end
        S_CHECK: begin
          covered_next = covered | (16'd1 << vec);
          if (F != EXPECT[vec]) begin
            mismatch_next = 1'b1;
            if (err_count != ERR_MAX) begin
              err_next = err_count + 5'd1;
            end
            if (!fail_seen) begin
              fail_seen_next  = 1'b1;
              fail_index_next = vec;
            end
          end
          state_next = (covered_next == ALL_COVERED) ? S_DONE : S_RUN;
        end
        default: begin
        end
      endcase
    end

    busy_next = (state_next == S_RUN) || (state_next == S_SETTLE) ||
                (state_next == S_CHECK);
    done_next = (state_next == S_DONE);
    pass_next = done_next && (err_next == 5'd0);
  end

  // Captured vector and settle countdown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec <= '0;
      cnt <= '0;
    end else begin
      vec <= vec_next;
      cnt <= cnt_next;
    end
  end

  // Registered outputs, so nothing reaches the ports combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      mismatch   <= 1'b0;
      err_count  <= '0;
      covered    <= '0;
      fail_seen  <= 1'b0;
      fail_index <= '0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      busy       <= busy_next;
      mismatch   <= mismatch_next;
      err_count  <= err_next;
      covered    <= covered_next;
      fail_seen  <= fail_seen_next;
      fail_index <= fail_index_next;
      done       <= done_next;
      pass       <= pass_next;
    end
  end

endmodule

// File: tb/tb_tt_response_checker.sv
// tb_tt_response_checker: randomized bench for tt_response_checker.
// A main instance uses SETTLE=2; a second instance with SETTLE=4 shares the
// inputs and is examined only by the retrigger scenario.
module tb_tt_response_checker;

  localparam int S  = 2;
  localparam int S4 = 4;

  logic        clk;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        A, B, C, D, F;

  logic        busy, mismatch, fail_seen, done, pass;
  logic [4:0]  err_count;
  logic [15:0] covered;
  logic [3:0]  fail_index;

  logic        busy4, mismatch4, fail_seen4, done4, pass4;
  logic [4:0]  err_count4;
  logic [15:0] covered4;
  logic [3:0]  fail_index4;

  logic [15:0] exp_tt;

  int n_checks;
  int n_errors;
  int mm_count;
  int mm4_count;

  // Reference model: results implied by the list of vectors that were checked
  bit          m_active;
  bit          m_done;
  int          m_err;
  logic [15:0] m_cov;
  bit          m_fail_seen;
  int          m_fail_idx;
  int          m_pulses;

  tt_response_checker #(.EXPECT(16'hA5F0), .SETTLE(S)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .A(A), .B(B), .C(C), .D(D), .F(F),
    .busy(busy), .mismatch(mismatch), .err_count(err_count),
    .covered(covered), .fail_seen(fail_seen), .fail_index(fail_index),
    .done(done), .pass(pass)
  );

  tt_response_checker #(.EXPECT(16'hA5F0), .SETTLE(S4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .A(A), .B(B), .C(C), .D(D), .F(F),
    .busy(busy4), .mismatch(mismatch4), .err_count(err_count4),
    .covered(covered4), .fail_seen(fail_seen4), .fail_index(fail_index4),
    .done(done4), .pass(pass4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count mismatch pulses, sampled on the falling edge
  always @(negedge clk) begin
    if (mismatch)  mm_count  = mm_count + 1;
    if (mismatch4) mm4_count = mm4_count + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic model_reset();
    m_active = 0; m_done = 0; m_err = 0; m_cov = '0;
    m_fail_seen = 0; m_fail_idx = 0;
  endtask

  task automatic model_start();
    m_active = 1; m_done = 0; m_err = 0; m_cov = '0;
    m_fail_seen = 0; m_fail_idx = 0;
  endtask

  task automatic model_apply(input int v, input logic f);
    if (m_active && !m_done) begin
      m_cov[v] = 1'b1;
      if (f != exp_tt[v]) begin
        m_pulses = m_pulses + 1;
        if (m_err < 31) m_err = m_err + 1;
        if (!m_fail_seen) begin
          m_fail_seen = 1;
          m_fail_idx  = v;
        end
      end
      if (m_cov == 16'hFFFF) m_done = 1;
    end
  endtask

  task automatic start_run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_start();
  endtask

  // One vector followed by enough idle cycles for its compare to complete
  task automatic send_vec(input int v, input logic f, input int gap);
    logic [3:0] vv;
    vv = 4'(v);
    @(negedge clk);
    {A, B, C, D} = vv;
    F = f;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (gap - 1) @(negedge clk);
    model_apply(v, f);
  endtask

  task automatic shuffle(output int p[16]);
    int j, t;
    for (int i = 0; i < 16; i++) p[i] = i;
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = p[i]; p[i] = p[j]; p[j] = t;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
    n_checks++; if (pass !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_pass: got %b want 0", pass); end
    n_checks++; if (err_count !== 5'd0) begin n_errors++; $display("[TB] FAIL reset_err: got %0d want 0", err_count); end
    n_checks++; if (covered !== 16'h0000) begin n_errors++; $display("[TB] FAIL reset_covered: got %h want 0000", covered); end
    n_checks++; if (fail_index !== 4'd0) begin n_errors++; $display("[TB] FAIL reset_fail_index: got %0d want 0", fail_index); end
    n_checks++; if ({fail_seen, mismatch} !== 2'b00) begin n_errors++; $display("[TB] FAIL reset_flags: got %b want 00", {fail_seen, mismatch}); end
  endtask

  task automatic test_latency();
    int v;
    logic f;
    logic want;
    start_run();
    n_checks++; if (busy !== 1'b1) begin n_errors++; $display("[TB] FAIL latency_busy: got %b want 1", busy); end
    v = $urandom_range(15, 0);
    f = ~exp_tt[v];
    @(negedge clk);
    {A, B, C, D} = 4'(v);
    F = f;
    in_valid = 1'b1;
    for (int j = 0; j <= S + 2; j++) begin
      @(negedge clk);
      in_valid = 1'b0;
      want = (j == S + 1);
      n_checks++;
      if (mismatch !== want) begin
        n_errors++;
        $display("[TB] FAIL latency_mismatch_cycle%0d: got %b want %b", j, mismatch, want);
      end
    end
    model_apply(v, f);
    n_checks++; if (covered !== m_cov) begin n_errors++; $display("[TB] FAIL latency_covered: got %h want %h", covered, m_cov); end
    n_checks++; if (err_count !== 5'(m_err)) begin n_errors++; $display("[TB] FAIL latency_err: got %0d want %0d", err_count, m_err); end
    n_checks++; if (fail_index !== 4'(m_fail_idx)) begin n_errors++; $display("[TB] FAIL latency_fail_index: got %0d want %0d", fail_index, m_fail_idx); end
  endtask

  task automatic test_sweep(input string name, input logic [15:0] flip);
    int base;
    start_run();
    base = mm_count;
    m_pulses = 0;
    for (int i = 0; i < 16; i++) send_vec(i, exp_tt[i] ^ flip[i], 19);
    n_checks++; if (mm_count - base !== m_pulses) begin n_errors++; $display("[TB] FAIL %s_pulses: got %0d want %0d", name, mm_count - base, m_pulses); end
    n_checks++; if (covered !== m_cov) begin n_errors++; $display("[TB] FAIL %s_covered: got %h want %h", name, covered, m_cov); end
    n_checks++; if (err_count !== 5'(m_err)) begin n_errors++; $display("[TB] FAIL %s_err: got %0d want %0d", name, err_count, m_err); end
    n_checks++; if (done !== m_done) begin n_errors++; $display("[TB] FAIL %s_done: got %b want %b", name, done, m_done); end
    n_checks++; if (pass !== (m_done && m_err == 0)) begin n_errors++; $display("[TB] FAIL %s_pass: got %b want %b", name, pass, m_done && m_err == 0); end
    n_checks++; if (fail_seen !== m_fail_seen) begin n_errors++; $display("[TB] FAIL %s_fail_seen: got %b want %b", name, fail_seen, m_fail_seen); end
    n_checks++; if (fail_index !== 4'(m_fail_idx)) begin n_errors++; $display("[TB] FAIL %s_fail_index: got %0d want %0d", name, fail_index, m_fail_idx); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("[TB] FAIL %s_busy: got %b want 0", name, busy); end
    // A vector arriving after completion must not change anything
    send_vec(3, ~exp_tt[3], S + 4);
    n_checks++; if (err_count !== 5'(m_err)) begin n_errors++; $display("[TB] FAIL %s_after_done_err: got %0d want %0d", name, err_count, m_err); end
    n_checks++; if (done !== 1'b1) begin n_errors++; $display("[TB] FAIL %s_after_done_done: got %b want 1", name, done); end
  endtask

  task automatic test_retrigger();
    int base4;
    start_run();
    base4 = mm4_count;
    @(negedge clk);
    {A, B, C, D} = 4'd3;
    F = ~exp_tt[3];
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    {A, B, C, D} = 4'd7;
    F = exp_tt[7];
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (S4 + 6) @(negedge clk);
    n_checks++; if (covered4 !== 16'h0080) begin n_errors++; $display("[TB] FAIL retrig_covered: got %h want 0080", covered4); end
    n_checks++; if (err_count4 !== 5'd0) begin n_errors++; $display("[TB] FAIL retrig_err: got %0d want 0", err_count4); end
    n_checks++; if (mm4_count - base4 !== 0) begin n_errors++; $display("[TB] FAIL retrig_pulses: got %0d want 0", mm4_count - base4); end
    n_checks++; if ({busy4, done4, pass4, fail_seen4} !== 4'b1000) begin n_errors++; $display("[TB] FAIL retrig_flags: got %b want 1000", {busy4, done4, pass4, fail_seen4}); end
    n_checks++; if (fail_index4 !== 4'd0) begin n_errors++; $display("[TB] FAIL retrig_fail_index: got %0d want 0", fail_index4); end
  endtask

  task automatic test_saturation();
    int p[16];
    int base;
    int k;
    start_run();
    base = mm_count;
    m_pulses = 0;
    shuffle(p);
    k = 0;
    for (int i = 0; i < 16; i++) begin
      if (p[i] != 15) begin
        send_vec(p[i], ~exp_tt[p[i]], $urandom_range(S + 5, S + 2));
        k++;
      end
    end
    for (int i = k; i < 40; i++) begin
      k = $urandom_range(14, 0);
      send_vec(k, ~exp_tt[k], $urandom_range(S + 5, S + 2));
    end
    n_checks++; if (err_count !== 5'(m_err)) begin n_errors++; $display("[TB] FAIL sat_err: got %0d want %0d", err_count, m_err); end
    n_checks++; if (covered !== m_cov) begin n_errors++; $display("[TB] FAIL sat_covered: got %h want %h", covered, m_cov); end
    n_checks++; if (done !== m_done) begin n_errors++; $display("[TB] FAIL sat_done: got %b want %b", done, m_done); end
    n_checks++; if (mm_count - base !== m_pulses) begin n_errors++; $display("[TB] FAIL sat_pulses: got %0d want %0d", mm_count - base, m_pulses); end
    send_vec(15, exp_tt[15], S + 3);
    n_checks++; if (done !== m_done) begin n_errors++; $display("[TB] FAIL sat_final_done: got %b want %b", done, m_done); end
    n_checks++; if (pass !== (m_done && m_err == 0)) begin n_errors++; $display("[TB] FAIL sat_final_pass: got %b want %b", pass, m_done && m_err == 0); end
    n_checks++; if (err_count !== 5'(m_err)) begin n_errors++; $display("[TB] FAIL sat_final_err: got %0d want %0d", err_count, m_err); end
    n_checks++; if (fail_index !== 4'(m_fail_idx)) begin n_errors++; $display("[TB] FAIL sat_fail_index: got %0d want %0d", fail_index, m_fail_idx); end
  endtask

  task automatic test_mid_reset();
    int p[16];
    int v;
    start_run();
    shuffle(p);
    for (int i = 0; i < 7; i++) send_vec(p[i], exp_tt[p[i]] ^ ($urandom_range(1, 0) == 1), S + 3);
    @(negedge clk);
    {A, B, C, D} = 4'(p[7]);
    F = exp_tt[p[7]];
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    model_reset();
    n_checks++; if ({busy, mismatch, fail_seen, done, pass} !== 5'b0) begin n_errors++; $display("[TB] FAIL midrst_flags: got %b want 00000", {busy, mismatch, fail_seen, done, pass}); end
    n_checks++; if (err_count !== 5'd0) begin n_errors++; $display("[TB] FAIL midrst_err: got %0d want 0", err_count); end
    n_checks++; if (covered !== 16'h0000) begin n_errors++; $display("[TB] FAIL midrst_covered: got %h want 0000", covered); end
    n_checks++; if (fail_index !== 4'd0) begin n_errors++; $display("[TB] FAIL midrst_fail_index: got %0d want 0", fail_index); end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v = $urandom_range(15, 0);
      send_vec(v, ~exp_tt[v], S + 3);
    end
    n_checks++; if ({busy, covered, err_count} !== 22'd0) begin n_errors++; $display("[TB] FAIL idle_ignore: got busy=%b covered=%h err=%0d want 0/0000/0", busy, covered, err_count); end
    start_run();
    shuffle(p);
    for (int i = 0; i < 16; i++) send_vec(p[i], exp_tt[p[i]], $urandom_range(S + 6, S + 2));
    n_checks++; if (pass !== (m_done && m_err == 0)) begin n_errors++; $display("[TB] FAIL restart_pass: got %b want %b", pass, m_done && m_err == 0); end
    n_checks++; if (covered !== m_cov) begin n_errors++; $display("[TB] FAIL restart_covered: got %h want %h", covered, m_cov); end
  endtask

  task automatic test_random();
    int v;
    int base;
    int steps;
    logic f;
    start_run();
    base = mm_count;
    m_pulses = 0;
    steps = 0;
    while (!m_done && steps < 300) begin
      v = $urandom_range(15, 0);
      f = exp_tt[v] ^ ($urandom_range(7, 0) == 0);
      send_vec(v, f, $urandom_range(S + 6, S + 2));
      steps++;
      n_checks++; if (covered !== m_cov) begin n_errors++; $display("[TB] FAIL rand_covered_step%0d: got %h want %h", steps, covered, m_cov); end
      n_checks++; if (err_count !== 5'(m_err)) begin n_errors++; $display("[TB] FAIL rand_err_step%0d: got %0d want %0d", steps, err_count, m_err); end
    end
    n_checks++; if (m_done !== 1'b1) begin n_errors++; $display("[TB] FAIL rand_budget: got %0d steps without full coverage want coverage", steps); end
    n_checks++; if (done !== m_done) begin n_errors++; $display("[TB] FAIL rand_done: got %b want %b", done, m_done); end
    n_checks++; if (pass !== (m_done && m_err == 0)) begin n_errors++; $display("[TB] FAIL rand_pass: got %b want %b", pass, m_done && m_err == 0); end
    n_checks++; if (fail_seen !== m_fail_seen) begin n_errors++; $display("[TB] FAIL rand_fail_seen: got %b want %b", fail_seen, m_fail_seen); end
    n_checks++; if (fail_index !== 4'(m_fail_idx)) begin n_errors++; $display("[TB] FAIL rand_fail_index: got %0d want %0d", fail_index, m_fail_idx); end
    n_checks++; if (mm_count - base !== m_pulses) begin n_errors++; $display("[TB] FAIL rand_pulses: got %0d want %0d", mm_count - base, m_pulses); end
  endtask

  initial begin
    exp_tt    = 16'hA5F0;
    n_checks  = 0;
    n_errors  = 0;
    mm_count  = 0;
    mm4_count = 0;
    m_pulses  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    in_valid  = 1'b0;
    {A, B, C, D} = 4'd0;
    F         = 1'b0;
    model_reset();

    $display("[TB] reset");
    test_reset();
    $display("[TB] latency");
    test_latency();
    $display("[TB] clean sweep");
    test_sweep("clean", 16'h0000);
    $display("[TB] faulty sweep");
    test_sweep("faulty", 16'h0220);
    $display("[TB] retrigger during settle");
    test_retrigger();
    $display("[TB] repeats and saturation");
    test_saturation();
    $display("[TB] mid-run reset and restart");
    test_mid_reset();
    $display("[TB] random run");
    test_random();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
